nv_ram_fifo_ctrl_80x14: RTL and testbench

- Single-clock FIFO controller that owns one 80x14 dual-port RAM bank: it drives the bank's write port (WE/WA/WD) and read port (RE/RA) and consumes its read data (RD).
- Exposes valid/ready push and pop interfaces to the surrounding datapath.
- Absorbs the bank's 1-cycle read latency with a 2-entry output skid buffer, so pop throughput is one word per cycle.

---
 rtl/nv_ram_fifo_ctrl_80x14.sv | 142 ++++++++++++++
 tb/tb_nv_ram_fifo_ctrl_80x14.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_fifo_ctrl_80x14.sv
// rtl/nv_ram_fifo_ctrl_80x14.sv - FIFO controller for one 80x14 dual-port RAM bank with 2-entry output skid buffer
// Optional FIFO_RD_BYPASS_EN: an empty FIFO forwards a push straight into the output register.
module nv_ram_fifo_ctrl_80x14 #(
  parameter int DEPTH = 80,
  parameter int WIDTH = 14,
  parameter int AW    = 7
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_wd,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  input  logic [WIDTH-1:0] ram_rd,
  output logic [6:0]       fifo_count
);

  localparam logic [6:0]    DEPTH_C = 7'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [6:0]       r_ram_cnt;
  logic             r_inflight;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_pd;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_pd;
  logic [6:0]       r_fifo_count;

  logic             w_push_fire;
  logic             w_pop_fire;
  logic             w_bypass;
  logic             w_ram_we;
  logic             w_issue;
  logic [1:0]       w_occ;
  logic [6:0]       w_ram_cnt_nxt;
  logic             w_out_vld_nxt;
  logic [WIDTH-1:0] w_out_pd_nxt;
  logic             w_skid_vld_nxt;
  logic [WIDTH-1:0] w_skid_pd_nxt;
  logic [6:0]       w_fifo_count_nxt;

  assign wr_prdy     = (r_ram_cnt < DEPTH_C);
  assign w_push_fire = wr_pvld & wr_prdy;
  assign w_pop_fire  = r_out_vld & rd_prdy;
  assign w_occ       = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_inflight};

`ifdef FIFO_RD_BYPASS_EN
  assign w_bypass = w_push_fire && (r_ram_cnt == 7'd0) && !r_inflight && !r_skid_vld &&
                    (!r_out_vld || w_pop_fire);
`else
  assign w_bypass = 1'b0;
`endif

  // Committed entries only: a word written this edge is not readable until next cycle.
  assign w_issue  = (r_ram_cnt != 7'd0) && ((w_occ - {1'b0, w_pop_fire}) < 2'd2);
  assign w_ram_we = w_push_fire & ~w_bypass;

  assign ram_we = w_ram_we;
  assign ram_wa = r_wr_ptr;
  assign ram_wd = wr_pd;
  assign ram_re = w_issue;
  assign ram_ra = r_rd_ptr;

  assign rd_pvld    = r_out_vld;
  assign rd_pd      = r_out_pd;
  assign fifo_count = r_fifo_count;

  always_comb begin
    w_out_vld_nxt  = r_out_vld;
    w_out_pd_nxt   = r_out_pd;
    w_skid_vld_nxt = r_skid_vld;
    w_skid_pd_nxt  = r_skid_pd;
    if (w_pop_fire && r_skid_vld) begin
      w_out_vld_nxt = 1'b1;
      w_out_pd_nxt  = r_skid_pd;
      if (r_inflight) begin
        w_skid_pd_nxt = ram_rd;
      end else begin
        w_skid_vld_nxt = 1'b0;
      end
    end else begin
      if (w_pop_fire) begin
        w_out_vld_nxt = 1'b0;
      end
      // Occupancy is capped at two, so a returning word always has a free slot.
      if (r_inflight) begin
        if (!r_out_vld || w_pop_fire) begin
          w_out_vld_nxt = 1'b1;
          w_out_pd_nxt  = ram_rd;
        end else begin
          w_skid_vld_nxt = 1'b1;
          w_skid_pd_nxt  = ram_rd;
        end
      end else if (w_bypass) begin
        w_out_vld_nxt = 1'b1;
        w_out_pd_nxt  = wr_pd;
      end
    end
  end

  assign w_ram_cnt_nxt    = r_ram_cnt + {6'd0, w_ram_we} - {6'd0, w_issue};
  assign w_fifo_count_nxt = w_ram_cnt_nxt + {6'd0, w_out_vld_nxt} +
                            {6'd0, w_skid_vld_nxt} + {6'd0, w_issue};

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_cnt    <= '0;
      r_inflight   <= 1'b0;
      r_out_vld    <= 1'b0;
      r_out_pd     <= '0;
      r_skid_vld   <= 1'b0;
      r_skid_pd    <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_ram_we) begin
        r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + AW'(1);
      end
      r_ram_cnt    <= w_ram_cnt_nxt;
      r_inflight   <= w_issue;
      r_out_vld    <= w_out_vld_nxt;
      r_out_pd     <= w_out_pd_nxt;
      r_skid_vld   <= w_skid_vld_nxt;
      r_skid_pd    <= w_skid_pd_nxt;
      r_fifo_count <= w_fifo_count_nxt;
    end
  end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x14.sv
// tb/tb_nv_ram_fifo_ctrl_80x14.sv - self-checking bench for nv_ram_fifo_ctrl_80x14 with a behavioural 80x14 RAM
module tb_nv_ram_fifo_ctrl_80x14;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [13:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [13:0] rd_pd;
  logic        ram_we;
  logic [6:0]  ram_wa;
  logic [13:0] ram_wd;
  logic        ram_re;
  logic [6:0]  ram_ra;
  logic [13:0] ram_rd = '0;
  logic [6:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] mem [0:79];
  logic [13:0] q[$];
  int          mcount;
  int          exp_wa;
  int          exp_ra;

  typedef struct {
    logic        pvld;
    logic [13:0] pd;
    logic        prdy;
    logic        e_we;
    logic [6:0]  e_wa;
    logic        e_re;
    logic [6:0]  e_ra;
    logic        e_rvld;
    logic [13:0] e_rpd;
    logic [6:0]  e_cnt;
  } vec_t;

  nv_ram_fifo_ctrl_80x14 dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .ram_we         (ram_we),
    .ram_wa         (ram_wa),
    .ram_wd         (ram_wd),
    .ram_re         (ram_re),
    .ram_ra         (ram_ra),
    .ram_rd         (ram_rd),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    if (ram_re) ram_rd <= mem[ram_ra];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcount = 0;
      exp_wa = 0;
      exp_ra = 0;
    end else begin
      check("fifo_count_model", 32'(fifo_count), 32'(mcount));
      if (ram_we) begin
        check("ram_wa_seq", 32'(ram_wa), 32'(exp_wa));
        check("ram_wd", 32'(ram_wd), 32'(wr_pd));
        exp_wa = (exp_wa == 79) ? 0 : exp_wa + 1;
      end
      if (ram_re) begin
        check("ram_ra_seq", 32'(ram_ra), 32'(exp_ra));
        exp_ra = (exp_ra == 79) ? 0 : exp_ra + 1;
      end
      if (rd_pvld && rd_prdy) begin
        if (q.size() == 0) begin
          check("pop_with_empty_model", 32'(q.size()), 32'd1);
        end else begin
          check("rd_pd_order", 32'(rd_pd), 32'(q.pop_front()));
        end
        mcount--;
      end
      if (wr_pvld && wr_prdy) begin
        q.push_back(wr_pd);
        mcount++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   first_rej;
    int   steady_exp;
    int   budget;
    bit   seen;

`ifdef FIFO_RD_BYPASS_EN
    tbl[0] = '{1'b1, 14'h1A5, 1'b1, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 14'h000, 7'd0};
    tbl[1] = '{1'b0, 14'h000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 14'h1A5, 7'd1};
    tbl[2] = '{1'b0, 14'h000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 14'h1A5, 7'd1};
    tbl[3] = '{1'b0, 14'h000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 14'h1A5, 7'd1};
    tbl[4] = '{1'b0, 14'h000, 1'b1, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 14'h1A5, 7'd1};
    tbl[5] = '{1'b0, 14'h000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 14'h000, 7'd0};
    steady_exp = 1;
`else
    tbl[0] = '{1'b1, 14'h1A5, 1'b1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 14'h000, 7'd0};
    tbl[1] = '{1'b0, 14'h000, 1'b1, 1'b0, 7'd0, 1'b1, 7'd0, 1'b0, 14'h000, 7'd1};
    tbl[2] = '{1'b0, 14'h000, 1'b1, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 14'h000, 7'd1};
    tbl[3] = '{1'b0, 14'h000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 14'h1A5, 7'd1};
    tbl[4] = '{1'b0, 14'h000, 1'b1, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 14'h1A5, 7'd1};
    tbl[5] = '{1'b0, 14'h000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 14'h000, 7'd0};
    steady_exp = 3;
`endif

    rst = 1'b1;
    wr_pvld = 1'b0;
    wr_pd = '0;
    rd_prdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_prdy", 32'(wr_prdy), 32'd1);
    check("rst_rd_pvld", 32'(rd_pvld), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_re", 32'(ram_re), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;

    // single-word latency table
    for (int i = 0; i < 6; i++) begin
      wr_pvld = tbl[i].pvld;
      wr_pd   = tbl[i].pd;
      rd_prdy = tbl[i].prdy;
      @(negedge clk);
      check($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) check($sformatf("tbl%0d_ram_wa", i), 32'(ram_wa), 32'(tbl[i].e_wa));
      check($sformatf("tbl%0d_ram_re", i), 32'(ram_re), 32'(tbl[i].e_re));
      if (tbl[i].e_re) check($sformatf("tbl%0d_ram_ra", i), 32'(ram_ra), 32'(tbl[i].e_ra));
      check($sformatf("tbl%0d_rd_pvld", i), 32'(rd_pvld), 32'(tbl[i].e_rvld));
      if (tbl[i].e_rvld) check($sformatf("tbl%0d_rd_pd", i), 32'(rd_pd), 32'(tbl[i].e_rpd));
      check($sformatf("tbl%0d_fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      check($sformatf("tbl%0d_wr_prdy", i), 32'(wr_prdy), 32'd1);
      @(posedge clk);
      #1;
    end

    // fill to full with pops blocked
    rd_prdy = 1'b0;
    first_rej = -1;
    for (int i = 0; i < 83; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = 14'(i);
      @(negedge clk);
      if (!wr_prdy && first_rej < 0) first_rej = i;
      @(posedge clk);
      #1;
    end
    wr_pvld = 1'b0;
    check("full_first_reject_idx", 32'(first_rej), 32'd82);
    @(negedge clk);
    check("full_wr_prdy", 32'(wr_prdy), 32'd0);
    check("full_fifo_count", 32'(fifo_count), 32'd82);
    check("full_rd_pvld", 32'(rd_pvld), 32'd1);
    @(posedge clk);
    #1;

    // drain in order, one per cycle
    rd_prdy = 1'b1;
    for (int i = 0; i < 82; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d_pvld", i), 32'(rd_pvld), 32'd1);
      check($sformatf("drain%0d_pd", i), 32'(rd_pd), 32'(i));
      if (i == 1) check("drain_wr_prdy_back", 32'(wr_prdy), 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("drained_rd_pvld", 32'(rd_pvld), 32'd0);
    check("drained_fifo_count", 32'(fifo_count), 32'd0);
    check("drained_model_q", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;

    // continuous streaming across pointer wrap
    for (int i = 0; i < 200; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = 14'((i * 37 + 5) & 16'h3FFF);
      @(negedge clk);
      if (i >= 4) check($sformatf("stream%0d_fifo_count", i), 32'(fifo_count), 32'(steady_exp));
      @(posedge clk);
      #1;
    end
    wr_pvld = 1'b0;
    budget = 0;
    while ((q.size() != 0) && (budget < 20)) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("stream_drain_timeout", 32'(budget < 20), 32'd1);

    // pop backpressure toggling every cycle
    for (int i = 0; i < 60; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = 14'(16'h2000 + i);
      rd_prdy = i[0];
      @(posedge clk);
      #1;
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    budget = 0;
    while ((q.size() != 0) && (budget < 60)) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("bp_drain_timeout", 32'(budget < 60), 32'd1);
    @(negedge clk);
    check("bp_final_count", 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;

    // reset asserted with 10 words held
    rd_prdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = 14'(100 + i);
      @(posedge clk);
      #1;
    end
    wr_pvld = 1'b0;
    @(negedge clk);
    check("pre_rst_count", 32'(fifo_count), 32'd10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_rd_pvld", 32'(rd_pvld), 32'd0);
    check("midrst_wr_prdy", 32'(wr_prdy), 32'd1);
    check("midrst_ram_re", 32'(ram_re), 32'd0);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_pvld = 1'b1;
    wr_pd   = 14'h2AB;
    rd_prdy = 1'b1;
    @(posedge clk);
    #1;
    wr_pvld = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rd_pvld) begin
        seen = 1'b1;
        check("post_rst_rd_pd", 32'(rd_pd), 32'h2AB);
      end
      @(posedge clk);
      #1;
    end
    check("post_rst_pop_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("post_rst_rd_pvld_clear", 32'(rd_pvld), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
